// File: rtl/bus_sequencer.sv
// Shared-bus sequencer: arbitrates CHANNELS requesters onto one address/data bus
// and runs each transaction through IDLE -> ACCESS (wait states) -> DONE.
module bus_sequencer #(
    parameter int CHANNELS    = 2,
    parameter int ADDR_W      = 23,
    parameter int DATA_W      = 16,
    parameter int WAIT_STATES = 1,
    parameter int PRIO_MODE   = 0
) (
    input  logic                     _CLK,
    input  logic                     RST,
    input  logic [CHANNELS-1:0]      REQ,
    input  logic [CHANNELS-1:0]      WE,
    input  logic [CHANNELS*ADDR_W-1:0] ADDR,
    input  logic [CHANNELS*DATA_W-1:0] WDATA,
    output logic [CHANNELS-1:0]      GNT,
    output logic [CHANNELS-1:0]      ACK,
    output logic [DATA_W-1:0]        RDATA,
    output logic [ADDR_W-1:0]        BUS_A,
    output logic [DATA_W-1:0]        BUS_D_OUT,
    output logic                     BUS_D_OE,
    input  logic [DATA_W-1:0]        BUS_D_IN,
    output logic                     BUS_R,
    output logic                     BUS_W,
    output logic                     BUSY
);

    localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0]          state;
    logic [IW-1:0]       win;
    logic [IW-1:0]       ptr;
    logic [IW-1:0]       pick;
    logic [IW-1:0]       base;
    logic [IW-1:0]       off;
    logic [IW:0]         sum;
    logic [CHANNELS-1:0] rot;
    logic [CHANNELS-1:0] cand;
    logic [CHANNELS-1:0] onehot;
    logic                found;
    logic                we_q;
    logic [3:0]          cnt;

    // Round-robin rotates the request vector so the pointer lands on bit 0;
    // the lowest set bit is then an offset from the pointer, wrapped back.
    always_comb begin
        rot   = CHANNELS'({REQ, REQ} >> ptr);
        cand  = (PRIO_MODE == 0) ? REQ : rot;
        base  = (PRIO_MODE == 0) ? '0 : ptr;
        off   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (!found && cand[i]) begin
                off   = IW'(i);
                found = 1'b1;
            end
        end
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= (IW+1)'(CHANNELS))
            sum = sum - (IW+1)'(CHANNELS);
        pick = sum[IW-1:0];
    end

    always_ff @(posedge _CLK) begin
        if (RST) begin
            state     <= IDLE;
            win       <= '0;
            ptr       <= '0;
            we_q      <= 1'b0;
            cnt       <= '0;
            BUS_A     <= '0;
            BUS_D_OUT <= '0;
            RDATA     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|REQ) begin
                        win       <= pick;
                        we_q      <= WE[pick];
                        BUS_A     <= ADDR[pick*ADDR_W +: ADDR_W];
                        BUS_D_OUT <= WDATA[pick*DATA_W +: DATA_W];
                        cnt       <= 4'(WAIT_STATES);
                        state     <= ACCESS;
                        if (PRIO_MODE != 0)
                            ptr <= (pick == IW'(CHANNELS-1)) ? '0 : pick + IW'(1);
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        if (!we_q)
                            RDATA <= BUS_D_IN;
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        onehot      = '0;
        onehot[win] = 1'b1;
        GNT         = (state != IDLE) ? onehot : '0;
        ACK         = (state == DONE) ? onehot : '0;
        BUS_R       = (state == ACCESS) && !we_q;
        BUS_W       = (state == ACCESS) && we_q;
        BUS_D_OE    = (state == ACCESS) && we_q;
        BUSY        = (state != IDLE);
    end

endmodule

// File: doc/bus_sequencer.md
Name: bus_sequencer

Overview:
- Parametrised shared-bus sequencer. Replaces the fixed clock-phase split of BUS_A/BUS_D/BUS_R/BUS_W between fetch and memory with an arbitrated, handshaked transaction engine.
- Serves CHANNELS requesters, for example fetch, memory and a future DMA/interrupt vector channel.
- Provides programmable wait states and a selectable arbitration mode.
- Sits between the pipeline stage bus clients and the devices block.

Parameters:
CHANNELS, 2, number of requesting clients (2..8); channel 0 is highest fixed priority
ADDR_W, 23, bus address width
DATA_W, 16, bus data width
WAIT_STATES, 1, extra ACCESS cycles per transaction (0..15)
PRIO_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin

Ports:
_CLK  in  1  single system clock, all state on rising edge
RST  in  1  synchronous reset, active-high
REQ  in  CHANNELS  per-channel request; held until ACK
WE  in  CHANNELS  per-channel write(1)/read(0); stable while REQ high
ADDR  in  CHANNELS*ADDR_W  packed addresses, channel i at [i*ADDR_W +: ADDR_W]
WDATA  in  CHANNELS*DATA_W  packed write data, same packing
GNT  out  CHANNELS  one-hot; marks the channel owning the bus
ACK  out  CHANNELS  one-cycle completion pulse to the owning channel
RDATA  out  DATA_W  read data; valid while ACK is high, held until next read completes
BUS_A  out  ADDR_W  bus address
BUS_D_OUT  out  DATA_W  bus write data
BUS_D_OE  out  1  write data drive enable
BUS_D_IN  in  DATA_W  bus read data from devices
BUS_R  out  1  read strobe
BUS_W  out  1  write strobe
BUSY  out  1  high in any state other than IDLE

Behaviour:
- Reset (RST high at an edge) forces state IDLE and clears every output: GNT, ACK, BUS_A, BUS_D_OUT, BUS_D_OE, BUS_R, BUS_W, BUSY and RDATA. Round-robin pointer resets to 0.
- Reset mid-transaction: strobes drop at that edge, no ACK is issued and the transaction is lost.
- FSM states:
  - IDLE: if any REQ bit is set, select a winner, register its channel index, latch ADDR/WE/WDATA into BUS_A/BUS_D_OUT, go to ACCESS. Otherwise stay.
  - ACCESS: GNT[win]=1. BUS_R=~WE or BUS_W=WE. BUS_D_OE=WE. The wait counter loads WAIT_STATES on entry and decrements each cycle. When the counter is 0, capture BUS_D_IN into RDATA (reads only) and go to DONE.
  - DONE: GNT[win]=1, ACK[win]=1, strobes and BUS_D_OE low, BUS_A held. Then go to IDLE.
- Latency: the REQ-sampled edge is followed by WAIT_STATES+1 ACCESS cycles and one DONE cycle. Bus occupancy is WAIT_STATES+3 cycles including the IDLE arbitration cycle.
- Arbitration:
  - PRIO_MODE 0: lowest set REQ index wins.
  - PRIO_MODE 1: search starts at the pointer and wraps modulo CHANNELS. On a grant, the pointer becomes win+1, wrapping CHANNELS-1 to 0.
- Request and address inputs are sampled only in IDLE. Changes during ACCESS/DONE are ignored.
- A REQ dropped mid-transaction does not abort it; ACK still pulses.
- The requester must deassert REQ in the cycle after ACK. A REQ still high in IDLE is treated as a new request.
- The wait counter width is 4 bits. WAIT_STATES=0 gives exactly one ACCESS cycle.
- GNT and ACK are always one-hot or zero. ACK is never high outside DONE.
- Simultaneous requests are resolved only by the arbitration mode. There is no starvation in round-robin mode.
- Writes leave RDATA unchanged.

Test Plan:
1. Reset: drive random REQ with RST high for 3 cycles, then release with REQ=0 -> all outputs 0, BUSY=0, RDATA=0x0000.
2. Single read (CHANNELS=2, WAIT_STATES=1): REQ=01, ADDR0=0x000123, BUS_D_IN=0xBEEF -> BUS_R high 2 cycles with BUS_A=0x000123, ACK=01 on the 4th cycle after the request, RDATA=0xBEEF.
3. Single write: REQ=10, WE=10, ADDR1=0x7FFFFF, WDATA1=0x1234 -> BUS_W and BUS_D_OE high 2 cycles, BUS_D_OUT=0x1234, ACK=10, RDATA unchanged.
4. Fixed priority: REQ=11 continuously, each re-asserted after ACK, PRIO_MODE=0 -> channel 0 granted every transaction, channel 1 never granted.
5. Round-robin (PRIO_MODE=1, CHANNELS=3): REQ=111 sustained -> grant order 0,1,2,0,1,2, with the pointer wrapping from 2 to 0.
6. Reset mid-ACCESS: assert RST on the second ACCESS cycle of a read -> BUS_R=0 and GNT=0 the next cycle, ACK never pulses, the next request is served normally.
